// File: rtl/instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// instr_fetch_unit: PC owner, imem req/gnt/rvalid master and prefetch FIFO feeding decode.
// Optional IFU_BYPASS_EN: a response arriving at an empty FIFO is presented to decode the same cycle.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 10,
  parameter int                  DEPTH       = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t                 state;
  logic                   req;
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    inflight_pc;

  logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
  logic [PC_WIDTH-1:0]    mem_pc    [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W:0]         count_after;

  logic                   fifo_valid;
  logic                   bypass;
  logic                   push;
  logic                   pop;
  logic                   space_after;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign fifo_valid = (count != '0);

`ifdef IFU_BYPASS_EN
  assign bypass = (state == S_WAIT) && imem_rvalid && !branch_taken && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response that decode accepts immediately never occupies a slot.
  assign push = (state == S_WAIT) && imem_rvalid && !branch_taken && !(bypass && instr_ready);
  assign pop  = fifo_valid && instr_ready && !branch_taken;

  always_comb begin
    count_after = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
  end

  assign space_after = (count_after < {1'b0, DEPTH_C});

  assign imem_req    = req;
  assign imem_addr   = fetch_pc;
  assign instr_valid = fifo_valid || bypass;
  assign instr       = bypass ? imem_rdata  : mem_instr[rd_ptr];
  assign instr_pc    = bypass ? inflight_pc : mem_pc[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      req         <= 1'b0;
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          if (branch_taken) begin
            fetch_pc <= branch_target;
          end else if (count < DEPTH_C) begin
            state <= S_REQ;
            req   <= 1'b1;
          end
        end
        S_REQ: begin
          if (branch_taken) begin
            fetch_pc <= branch_target;
            req      <= 1'b0;
            state    <= imem_gnt ? S_DROP : S_IDLE;
          end else if (imem_gnt) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 1'b1;
            req         <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (branch_taken) begin
            fetch_pc <= branch_target;
            state    <= imem_rvalid ? S_IDLE : S_DROP;
          end else if (imem_rvalid) begin
            if (space_after) begin
              state <= S_REQ;
              req   <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (branch_taken) begin
            fetch_pc <= branch_target;
          end
          // The stale response retires the drop even if another redirect lands with it.
          if (imem_rvalid) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (branch_taken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= imem_rdata;
        mem_pc[wr_ptr]    <= inflight_pc;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_after[CNT_W-1:0];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count == DEPTH_C)));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for instr_fetch_unit: zero-wait memory model, expected instr/addr queues.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_gnt;
  logic       imem_rvalid;
  logic [9:0] imem_rdata;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       instr_valid;
  logic [9:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready;

  logic       hold;
  logic       pending;
  logic [7:0] pend_addr;

  int checks = 0;
  int passes = 0;

`ifdef IFU_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] pc;
    logic [9:0] ins;
  } exp_t;

  exp_t       exp_q  [$];
  logic [7:0] addr_q [$];

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready)
  );

  always #5 clk = ~clk;

  // Memory image: word at address a is {2'b10, a ^ 8'hA5}, e.g. 0x00 -> 10'h2A5.
  function automatic logic [9:0] mem_word(input logic [7:0] a);
    return {2'b10, a ^ 8'hA5};
  endfunction

  assign imem_gnt    = imem_req;
  assign imem_rvalid = pending && !hold;
  assign imem_rdata  = pending ? mem_word(pend_addr) : 10'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= 1'b0;
      pend_addr <= 8'd0;
    end else if (imem_req && imem_gnt) begin
      pending   <= 1'b1;
      pend_addr <= imem_addr;
    end else if (imem_rvalid) begin
      pending   <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic expect_fetch(input logic [7:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
    addr_q.push_back(pc);
  endtask

  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready && !branch_taken) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_instr: got pc=%0h instr=%0h, expected none", instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr_pc", 32'(instr_pc), 32'(e.pc));
        check("instr", 32'(instr), 32'(e.ins));
      end
    end
    if (reset && imem_req && imem_gnt && addr_q.size() != 0) begin
      logic [7:0] a;
      a = addr_q.pop_front();
      check("imem_addr", 32'(imem_addr), 32'(a));
    end
  end

  task automatic restart();
    @(posedge clk); #1;
    reset        = 1'b0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    hold         = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    instr_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL %s_timeout: %0d entries left, expected 0", name, exp_q.size());
    end
    check({name, "_addr_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset         = 1'b0;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'd0;
    hold          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_addr",  32'(imem_addr),   32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr),       32'd0);
    check("rst_pc",    32'(instr_pc),    32'd0);

    // Sequential fetch with decode always ready.
    for (int i = 0; i < 6; i++) expect_fetch(8'(i));
    instr_ready = 1'b1;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("lat_e2_valid", 32'(instr_valid), 32'(BYPASS));
    @(posedge clk); #1;
    check("lat_e3_valid", 32'(instr_valid), 32'(!BYPASS));
    drain("t1");

    // Decode stalled: FIFO fills to two, fetch halts, head holds 0x00.
    restart();
    for (int i = 0; i < 4; i++) expect_fetch(8'(i));
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t2_req_idle", 32'(imem_req),    32'd0);
    check("t2_valid",    32'(instr_valid), 32'd1);
    check("t2_head_pc",  32'(instr_pc),    32'd0);
    check("t2_head",     32'(instr),       32'(mem_word(8'h00)));
    instr_ready = 1'b1;
    drain("t2");

    // Redirect to 0x40 while waiting on the 0x05 response.
    restart();
    for (int i = 0; i < 5; i++) expect_fetch(8'(i));
    addr_q.push_back(8'h05);
    expect_fetch(8'h40);
    expect_fetch(8'h41);
    expect_fetch(8'h42);
    instr_ready = 1'b1;
    reset       = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 8'h05) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    hold = 1'b1;
    @(posedge clk); #1;
    branch_taken  = 1'b1;
    branch_target = 8'h40;
    @(posedge clk); #1;
    branch_taken = 1'b0;
    hold         = 1'b0;
    drain("t3");

    // Redirect near the top of the address space wraps.
    restart();
    expect_fetch(8'hFE);
    expect_fetch(8'hFF);
    expect_fetch(8'h00);
    instr_ready   = 1'b1;
    reset         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'hFE;
    @(posedge clk); #1;
    branch_taken = 1'b0;
    drain("t4");

    // Redirect coinciding with rvalid and a pop while one entry is buffered.
    restart();
    addr_q.push_back(8'h00);
    addr_q.push_back(8'h01);
    expect_fetch(8'h80);
    expect_fetch(8'h81);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5_pre_valid", 32'(instr_valid), 32'd1);
    check("t5_pre_pc",    32'(instr_pc),    32'd0);
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'h80;
    @(posedge clk); #1;
    branch_taken = 1'b0;
    check("t5_flushed", 32'(instr_valid), 32'd0);
    check("t5_req_off", 32'(imem_req),    32'd0);
    @(posedge clk); #1;
    check("t5_req_on",  32'(imem_req),    32'd1);
    check("t5_addr",    32'(imem_addr),   32'h80);
    drain("t5");

    // Asynchronous reset while a request is pending and the FIFO holds data.
    restart();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_pre_req",   32'(imem_req),    32'd1);
    check("t6_pre_valid", 32'(instr_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_req",   32'(imem_req),    32'd0);
    check("t6_rst_valid", 32'(instr_valid), 32'd0);
    check("t6_rst_addr",  32'(imem_addr),   32'd0);
    check("t6_rst_pc",    32'(instr_pc),    32'd0);
    repeat (2) @(posedge clk);
    #1;
    expect_fetch(8'h00);
    expect_fetch(8'h01);
    instr_ready = 1'b1;
    reset       = 1'b1;
    drain("t6");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
